pf_lanectrl_dly_seq: RTL

//  Multi-lane delay-line step sequencer for the PF IOD lane controllers. Takes one
//  tap command at a time (move up/down N steps, load, read) for any of NUM_LANES lanes.

---
 rtl/pf_lanectrl_dly_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pf_lanectrl_dly_seq.sv
// Multi-lane delay-line tap sequencer between training logic and the PF IOD LANECTRL blocks.
// Define PF_LANECTRL_DLY_SEQ_PAUSE_EN to bracket moves/loads with an HS_IO_CLK_PAUSE window.
module pf_lanectrl_dly_seq #(
   parameter int unsigned NUM_LANES     = 4,
   parameter int unsigned TAP_W         = 8,
   parameter int unsigned MAX_TAP       = 255,
   parameter int unsigned LOAD_TAP      = 1,
   parameter int unsigned PAUSE_EXT_CYC = 2,
   parameter int unsigned SETTLE_CYC    = 4,
   localparam int unsigned LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                 fab_clk,
   input  logic                 arst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [LANE_W-1:0]    cmd_lane,
   input  logic [1:0]           cmd_op,
   input  logic [TAP_W-1:0]     cmd_steps,
   input  logic [NUM_LANES-1:0] dly_oor_in,
   output logic                 hs_io_clk_pause,
   output logic [NUM_LANES-1:0] delay_line_move,
   output logic [NUM_LANES-1:0] delay_line_direction,
   output logic [NUM_LANES-1:0] delay_line_load,
   output logic                 rsp_valid,
   output logic [TAP_W-1:0]     rsp_tap,
   output logic                 rsp_oor,
   output logic                 rsp_err
);

   localparam logic [1:0] OpUp   = 2'b00;
   localparam logic [1:0] OpDn   = 2'b01;
   localparam logic [1:0] OpRead = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StPause, StStepHi, StStepLo, StLoad, StRelease, StResp
   } state_e;

   state_e state_q, state_d, first_state, post_state;

   logic [LANE_W-1:0]    lane_q, eff_lane;
   logic [1:0]           op_q, eff_op;
   logic [TAP_W-1:0]     steps_q, eff_steps;
   logic [15:0]          cnt_q;
   logic                 err_q, oor_q;
   logic [TAP_W-1:0]     tap_q [NUM_LANES];
   logic [NUM_LANES-1:0] lane_oh;
   logic [TAP_W-1:0]     cur_tap;
   logic                 oor_sel, at_limit, lane_ok, accept, stop_oor, first_oor;
   logic                 rsp_valid_q, rsp_oor_q, rsp_err_q;
   logic [TAP_W-1:0]     rsp_tap_q;

   assign accept  = cmd_valid && (state_q == StIdle);
   assign lane_ok = 32'(cmd_lane) < NUM_LANES;

   // In IDLE the range check looks at the incoming command so the first step can start at once.
   always_comb begin : p_sel
      eff_lane  = (state_q == StIdle) ? cmd_lane  : lane_q;
      eff_op    = (state_q == StIdle) ? cmd_op    : op_q;
      eff_steps = (state_q == StIdle) ? cmd_steps : steps_q;
      cur_tap   = '0;
      oor_sel   = 1'b0;
      lane_oh   = '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         if (eff_lane == LANE_W'(i)) begin
            cur_tap = tap_q[i];
         end
         if (lane_q == LANE_W'(i)) begin
            lane_oh[i] = 1'b1;
            oor_sel    = dly_oor_in[i];
         end
      end
      at_limit = (eff_op == OpDn) ? (cur_tap == '0) : (cur_tap == TAP_W'(MAX_TAP));
   end

`ifdef PF_LANECTRL_DLY_SEQ_PAUSE_EN
   // The RESP cycle is the last settle cycle, so RELEASE itself lasts SETTLE_CYC-1.
   assign post_state = (SETTLE_CYC > 1) ? StRelease : StResp;
`else
   assign post_state = StResp;
`endif

   always_comb begin : p_first
      first_oor = 1'b0;
      if (eff_op == 2'b10) begin
         first_state = StLoad;
      end else if (eff_steps == '0) begin
         first_state = post_state;
      end else if (at_limit) begin
         first_state = post_state;
         first_oor   = 1'b1;
      end else begin
         first_state = StStepHi;
      end
   end

   always_ff @(posedge fab_clk or negedge arst_n) begin : p_state
      if (!arst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : p_next
      state_d  = state_q;
      stop_oor = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (!lane_ok || cmd_op == OpRead) begin
                  state_d = StResp;
               end else begin
`ifdef PF_LANECTRL_DLY_SEQ_PAUSE_EN
                  state_d = StPause;
`else
                  state_d  = first_state;
                  stop_oor = first_oor;
`endif
               end
            end
         end
         StPause: begin
            if (cnt_q == 16'(PAUSE_EXT_CYC - 1)) begin
               state_d  = first_state;
               stop_oor = first_oor;
            end
         end
         StStepHi: state_d = StStepLo;
         StStepLo: begin
            if (steps_q == TAP_W'(1)) begin
               state_d = post_state;
            end else if (at_limit || oor_sel) begin
               state_d  = post_state;
               stop_oor = 1'b1;
            end else begin
               state_d = StStepHi;
            end
         end
         StLoad: state_d = post_state;
         StRelease: begin
            if (cnt_q == 16'(SETTLE_CYC - 2)) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge fab_clk or negedge arst_n) begin : p_data
      if (!arst_n) begin
         lane_q      <= '0;
         op_q        <= '0;
         steps_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         oor_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tap_q   <= '0;
         rsp_oor_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         for (int i = 0; i < int'(NUM_LANES); i++) begin
            tap_q[i] <= TAP_W'(LOAD_TAP);
         end
      end else begin
         cnt_q <= (state_d != state_q) ? '0 : cnt_q + 16'd1;
         if (accept) begin
            lane_q  <= cmd_lane;
            op_q    <= cmd_op;
            steps_q <= cmd_steps;
            err_q   <= !lane_ok;
         end else if (state_q == StStepLo) begin
            steps_q <= steps_q - TAP_W'(1);
         end
         oor_q <= accept ? stop_oor : (oor_q | stop_oor);
         for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (lane_oh[i] && state_q == StStepHi) begin
               tap_q[i] <= (op_q == OpDn) ? tap_q[i] - TAP_W'(1) : tap_q[i] + TAP_W'(1);
            end else if (lane_oh[i] && state_q == StLoad) begin
               tap_q[i] <= TAP_W'(LOAD_TAP);
            end
         end
         rsp_valid_q <= (state_q == StResp);
         if (state_q == StResp) begin
            rsp_tap_q <= err_q ? '0 : cur_tap;
            rsp_oor_q <= oor_q;
            rsp_err_q <= err_q;
         end
      end
   end

   always_comb begin : p_out
      cmd_ready            = (state_q == StIdle);
      delay_line_move      = (state_q == StStepHi) ? lane_oh : '0;
      delay_line_load      = (state_q == StLoad) ? lane_oh : '0;
      delay_line_direction = '0;
      if (op_q == OpUp &&
          (state_q inside {StPause, StStepHi, StStepLo, StRelease})) begin
         delay_line_direction = lane_oh;
      end
`ifdef PF_LANECTRL_DLY_SEQ_PAUSE_EN
      hs_io_clk_pause = (state_q inside {StPause, StStepHi, StStepLo, StLoad});
`else
      hs_io_clk_pause = 1'b0;
`endif
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tap   = rsp_tap_q;
   assign rsp_oor   = rsp_oor_q;
   assign rsp_err   = rsp_err_q;

endmodule
